ics_poll_scheduler: RTL and testbench

//  Sequences periodic ICS servo polling. Each tick from the interval timer starts one

---
 rtl/ics_if_pkg.sv | 22 ++
 rtl/ics_ch_picker.sv | 25 ++
 rtl/ics_poll_scheduler.sv | 135 +++++++++++++
 tb/tb_ics_poll_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ics_if_pkg.sv
// Shared types, default widths and helpers for the ICS poll scheduler.
package ics_if_pkg;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_CH_W   = 2;
  localparam int unsigned DEF_TMO_W  = 16;
  localparam int unsigned DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ics_ch_picker.sv
// Finds the lowest set mask bit strictly above cur_i, or the lowest set bit at all
// when from_start_i is high.
module ics_ch_picker #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [CH_W-1:0]   cur_i,
  input  logic              from_start_i,
  output logic [CH_W-1:0]   next_o,
  output logic              found_o
);

  always_comb begin
    found_o = 1'b0;
    next_o  = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!found_o && mask_i[i] && (from_start_i || i > int'(cur_i))) begin
        found_o = 1'b1;
        next_o  = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/ics_poll_scheduler.sv
// Per-tick poll frame sequencer: one request per enabled channel, with per-transaction
// timeout and saturating timeout/overrun status counters.
module ics_poll_scheduler
  import ics_if_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned CH_W   = DEF_CH_W,
  parameter int unsigned TMO_W  = DEF_TMO_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              tick_i,
  input  logic              enable_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic [TMO_W-1:0]  timeout_i,
  output logic              req_valid_o,
  output logic [CH_W-1:0]   req_ch_o,
  input  logic              req_ready_i,
  input  logic              done_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [CNT_W-1:0]  timeout_cnt_o,
  output logic [CNT_W-1:0]  overrun_cnt_o,
  input  logic              clear_i
);

  state_e             state_q;
  logic [NUM_CH-1:0]  mask_q;
  logic [CH_W-1:0]    ch_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               tmo_en_q;
  logic [CNT_W-1:0]   timeout_cnt_q;
  logic [CNT_W-1:0]   overrun_cnt_q;

  logic [NUM_CH-1:0]  pick_mask;
  logic               pick_start;
  logic [CH_W-1:0]    pick_idx;
  logic               pick_found;

  logic               tmo_expire;
  logic               txn_end;
  logic               frame_start;
  logic               timeout_inc;
  logic               overrun_inc;

  // One picker serves both frame start (live mask, from -1) and advance (latched mask).
  always_comb begin
    pick_start = (state_q == StIdle);
    pick_mask  = pick_start ? ch_mask_i : mask_q;
  end

  ics_ch_picker #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_picker (
    .mask_i       (pick_mask),
    .cur_i        (ch_q),
    .from_start_i (pick_start),
    .next_o       (pick_idx),
    .found_o      (pick_found)
  );

  always_comb begin
    tmo_expire  = tmo_en_q && (tmo_q == TMO_W'(1));
    txn_end     = (state_q == StWait) && (done_i || tmo_expire);
    frame_start = (state_q == StIdle) && tick_i && enable_i && (|ch_mask_i);
    timeout_inc = (state_q == StWait) && tmo_expire && !done_i;
    overrun_inc = tick_i && (state_q != StIdle);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= StIdle;
      mask_q   <= '0;
      ch_q     <= '0;
      tmo_q    <= '0;
      tmo_en_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (frame_start) begin
            mask_q  <= ch_mask_i;
            ch_q    <= pick_idx;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          // Request is held regardless of enable_i until the engine takes it.
          if (req_ready_i) begin
            tmo_q    <= timeout_i;
            tmo_en_q <= |timeout_i;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (txn_end) begin
            if (enable_i && pick_found) begin
              ch_q    <= pick_idx;
              state_q <= StIssue;
            end else begin
              state_q <= StIdle;
            end
          end else if (tmo_q != '0) begin
            tmo_q <= tmo_q - TMO_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      timeout_cnt_q <= '0;
      overrun_cnt_q <= '0;
    end else if (clear_i) begin
      timeout_cnt_q <= '0;
      overrun_cnt_q <= '0;
    end else begin
      if (timeout_inc) timeout_cnt_q <= CNT_W'(sat_inc(32'(timeout_cnt_q), CNT_W));
      if (overrun_inc) overrun_cnt_q <= CNT_W'(sat_inc(32'(overrun_cnt_q), CNT_W));
    end
  end

  // frame_done_o marks the WAIT cycle that closes the last transaction, so busy_o is
  // still high there and a coincident tick is counted as an overrun.
  assign frame_done_o  = txn_end && enable_i && !pick_found;
  assign busy_o        = (state_q != StIdle);
  assign req_valid_o   = (state_q == StIssue);
  assign req_ch_o      = ch_q;
  assign timeout_cnt_o = timeout_cnt_q;
  assign overrun_cnt_o = overrun_cnt_q;

endmodule

// File: tb/tb_ics_poll_scheduler.sv
// Directed self-checking bench for ics_poll_scheduler.
module tb_ics_poll_scheduler;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        tick_i;
  logic        enable_i;
  logic [3:0]  ch_mask_i;
  logic [15:0] timeout_i;
  logic        req_valid_o;
  logic [1:0]  req_ch_o;
  logic        req_ready_i;
  logic        done_i;
  logic        busy_o;
  logic        frame_done_o;
  logic [7:0]  timeout_cnt_o;
  logic [7:0]  overrun_cnt_o;
  logic        clear_i;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  ics_poll_scheduler #(
    .NUM_CH (4),
    .CH_W   (2),
    .TMO_W  (16),
    .CNT_W  (8)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .tick_i        (tick_i),
    .enable_i      (enable_i),
    .ch_mask_i     (ch_mask_i),
    .timeout_i     (timeout_i),
    .req_valid_o   (req_valid_o),
    .req_ch_o      (req_ch_o),
    .req_ready_i   (req_ready_i),
    .done_i        (done_i),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o),
    .timeout_cnt_o (timeout_cnt_o),
    .overrun_cnt_o (overrun_cnt_o),
    .clear_i       (clear_i)
  );

  always #5 ap_clk = ~ap_clk;

  always @(negedge ap_clk) if (frame_done_o) fd_cnt <= fd_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_tick();
    tick_i = 1'b1;
    cyc();
    tick_i = 1'b0;
  endtask

  task automatic wait_valid();
    int w = 0;
    while (!req_valid_o && w < 30) begin
      cyc();
      w++;
    end
  endtask

  // Engine with ready=1: accept, then done 'delay' cycles after the accept edge.
  task automatic do_txn(input int exp_ch, input int delay, input logic last);
    wait_valid();
    chk("req_valid", 32'(req_valid_o), 1);
    chk("req_ch", 32'(req_ch_o), 32'(exp_ch));
    cyc();
    repeat (delay - 1) cyc();
    done_i = 1'b1;
    #1;
    chk("frame_done_at_done", 32'(frame_done_o), 32'(last));
    cyc();
    done_i = 1'b0;
  endtask

  initial begin
    logic stable;
    int   w;
    ap_rst_n    = 1'b0;
    tick_i      = 1'b0;
    enable_i    = 1'b1;
    ch_mask_i   = 4'b0000;
    timeout_i   = 16'd0;
    req_ready_i = 1'b1;
    done_i      = 1'b0;
    clear_i     = 1'b0;
    cyc();
    cyc();
    chk("rst_valid", 32'(req_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_fd", 32'(frame_done_o), 0);
    chk("rst_tmo_cnt", 32'(timeout_cnt_o), 0);
    chk("rst_ovr_cnt", 32'(overrun_cnt_o), 0);
    ap_rst_n = 1'b1;
    cyc();

    // Zero mask tick is ignored.
    pulse_tick();
    chk("zero_mask_busy", 32'(busy_o), 0);
    chk("zero_mask_ovr", 32'(overrun_cnt_o), 0);

    // 1: mask 1011 -> ch0, ch1, ch3
    ch_mask_i = 4'b1011;
    timeout_i = 16'd100;
    pulse_tick();
    do_txn(0, 5, 1'b0);
    do_txn(1, 5, 1'b0);
    do_txn(3, 5, 1'b1);
    chk("t1_busy_end", 32'(busy_o), 0);
    chk("t1_fd_cnt", 32'(fd_cnt), 1);
    chk("t1_tmo_cnt", 32'(timeout_cnt_o), 0);
    chk("t1_ovr_cnt", 32'(overrun_cnt_o), 0);

    // 2: timeout after exactly 20 WAIT cycles
    ch_mask_i = 4'b0001;
    timeout_i = 16'd20;
    pulse_tick();
    wait_valid();
    cyc();
    repeat (18) cyc();
    chk("t2_fd_cycle19", 32'(frame_done_o), 0);
    cyc();
    chk("t2_fd_cycle20", 32'(frame_done_o), 1);
    chk("t2_busy_cycle20", 32'(busy_o), 1);
    cyc();
    chk("t2_tmo_cnt", 32'(timeout_cnt_o), 1);
    chk("t2_busy_end", 32'(busy_o), 0);
    chk("t2_fd_cnt", 32'(fd_cnt), 2);

    // 3: ready low 10 cycles, request held steady
    ch_mask_i   = 4'b0100;
    timeout_i   = 16'd0;
    req_ready_i = 1'b0;
    pulse_tick();
    wait_valid();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (req_valid_o !== 1'b1 || req_ch_o !== 2'd2) stable = 1'b0;
      cyc();
    end
    chk("t3_held_stable", 32'(stable), 1);
    chk("t3_still_valid", 32'(req_valid_o), 1);
    req_ready_i = 1'b1;
    cyc();
    chk("t3_accepted", 32'(req_valid_o), 0);
    chk("t3_busy_wait", 32'(busy_o), 1);
    repeat (30) cyc();
    chk("t3_no_tmo_when_0", 32'(timeout_cnt_o), 1);
    done_i = 1'b1;
    #1;
    chk("t3_fd", 32'(frame_done_o), 1);
    cyc();
    done_i = 1'b0;

    // 4: overruns mid-frame and on frame_done cycle
    ch_mask_i = 4'b0011;
    pulse_tick();
    wait_valid();
    cyc();
    pulse_tick();
    chk("t4_ovr_mid", 32'(overrun_cnt_o), 1);
    done_i = 1'b1;
    cyc();
    done_i = 1'b0;
    chk("t4_ch1", 32'(req_ch_o), 1);
    cyc();
    done_i = 1'b1;
    tick_i = 1'b1;
    #1;
    chk("t4_fd", 32'(frame_done_o), 1);
    cyc();
    done_i = 1'b0;
    tick_i = 1'b0;
    chk("t4_ovr_cnt", 32'(overrun_cnt_o), 2);
    chk("t4_busy", 32'(busy_o), 0);
    repeat (3) cyc();
    chk("t4_no_new_frame", 32'(busy_o), 0);
    chk("t4_fd_cnt", 32'(fd_cnt), 4);

    // 5: enable dropped while waiting on ch1
    ch_mask_i = 4'b1111;
    pulse_tick();
    do_txn(0, 2, 1'b0);
    chk("t5_ch1", 32'(req_ch_o), 1);
    cyc();
    enable_i = 1'b0;
    cyc();
    chk("t5_busy_wait", 32'(busy_o), 1);
    done_i = 1'b1;
    #1;
    chk("t5_no_fd", 32'(frame_done_o), 0);
    cyc();
    done_i = 1'b0;
    chk("t5_busy", 32'(busy_o), 0);
    chk("t5_no_ch2", 32'(req_valid_o), 0);
    chk("t5_fd_cnt", 32'(fd_cnt), 4);
    enable_i = 1'b1;

    // 6: timeout counter saturation and clear
    ch_mask_i = 4'b1111;
    timeout_i = 16'd1;
    for (int f = 0; f < 75; f++) begin
      pulse_tick();
      w = 0;
      while (busy_o && w < 50) begin
        cyc();
        w++;
      end
      if (f == 9) chk("t6_tmo_41", 32'(timeout_cnt_o), 41);
    end
    chk("t6_tmo_sat", 32'(timeout_cnt_o), 255);
    chk("t6_ovr_kept", 32'(overrun_cnt_o), 2);
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    chk("t6_clr_tmo", 32'(timeout_cnt_o), 0);
    chk("t6_clr_ovr", 32'(overrun_cnt_o), 0);

    // clear wins over a same-cycle timeout increment
    ch_mask_i = 4'b0001;
    pulse_tick();
    cyc();
    clear_i = 1'b1;
    #1;
    chk("t6_expire_cycle", 32'(frame_done_o), 1);
    cyc();
    clear_i = 1'b0;
    chk("t6_clear_wins", 32'(timeout_cnt_o), 0);

    // reset asserted in WAIT
    timeout_i = 16'd0;
    pulse_tick();
    wait_valid();
    cyc();
    chk("t6_in_wait", 32'(busy_o), 1);
    ap_rst_n = 1'b0;
    cyc();
    chk("rst2_busy", 32'(busy_o), 0);
    chk("rst2_valid", 32'(req_valid_o), 0);
    chk("rst2_ch", 32'(req_ch_o), 0);
    chk("rst2_fd", 32'(frame_done_o), 0);
    ap_rst_n = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
